sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have one parameter: N_SAMPLES, default 8, number of adder results accumulated per run (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: begin a new accumulation run.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_sum/in_cout carry a valid adder result.
REQ-006 The block SHALL have port in_sum, input, 8 bits: sum output of the upstream 8-bit adder.
REQ-007 The block SHALL have port in_cout, input, 1 bit: carry output of the upstream 8-bit adder.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts an input word this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: acc_out holds a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port acc_out, output, 12 bits: accumulator value.
REQ-012 The block SHALL have port acc_ovf, output, 1 bit: sticky accumulator overflow flag.
REQ-013 The block SHALL have port count, output, 4 bits: number of words accepted in the current run.

Function
REQ-014 The operand value SHALL be the 9-bit unsigned {in_cout, in_sum} (0..511), zero-extended to 12 bits.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE: in_ready=0 and out_valid=0; start=1 clears acc_out, count and acc_ovf and moves to ACCUM on the next edge.
REQ-017 In ACCUM: in_ready=1; an input is accepted only on cycles with in_valid=1 and in_ready=1.
REQ-018 On each accept: acc_out <= (acc_out + operand) mod 4096 and count <= count + 1.
REQ-019 acc_ovf SHALL set when any accept's 12-bit add carries out, and SHALL remain set until the next start or reset.
REQ-020 The accept that makes count reach N_SAMPLES SHALL move the FSM to DONE; out_valid is asserted on the following cycle (1-cycle latency).
REQ-021 Cycles in ACCUM with in_valid=0 SHALL leave acc_out, count and acc_ovf unchanged.
REQ-022 In DONE: out_valid=1 and in_ready=0; in_valid is ignored; acc_out, acc_ovf and count are held stable.
REQ-023 In DONE, out_valid=1 together with out_ready=1 completes the result handshake; the FSM returns to IDLE on that edge, with outputs retaining their values.
REQ-024 out_ready is ignored outside DONE.
REQ-025 start is ignored in ACCUM and DONE.
REQ-026 start=1 in IDLE on the cycle after a DONE handshake SHALL begin a new run normally.
REQ-027 All outputs SHALL be driven from registers or from the FSM state only; there is no combinational path from any input to any output.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and set acc_out=0, acc_ovf=0, count=0, in_ready=0 and out_valid=0.
REQ-029 Reset asserted mid-run (in ACCUM or DONE) SHALL discard the partial result; after release, the block stays in IDLE until start.
REQ-030 Reset release SHALL be sampled on clk; the first edge with rst_n=1 may take a start.

Verification
REQ-031 Default N=8; start, then 8 accepts of in_cout=1, in_sum=8'h8E (398) -> out_valid=1, acc_out=12'hC70, acc_ovf=0, count=8.
REQ-032 Default N=8; 8 accepts of {1, 8'hFF} (511) with in_valid=0 bubbles between words -> bubbles not counted; acc_out=12'hFF8, acc_ovf=0.
REQ-033 N_SAMPLES=9; 9 accepts of 511 -> acc_out=12'h1F7, acc_ovf=1.
REQ-034 In DONE with out_ready=0 for 5 cycles while in_valid=1 -> out_valid stays 1, in_ready=0, acc_out unchanged; out_ready=1 -> IDLE on next edge, out_valid=0.
REQ-035 After 3 accepts of 100, rst_n=0 between clock edges -> acc_out=0, count=0, in_ready=0 immediately; a further start then 8 accepts of 1 -> acc_out=8.
REQ-036 start pulsed during ACCUM after 2 accepts -> ignored; the run finishes after 6 more accepts with the full 8-word sum.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES 9-bit adder results ({cout, sum}) into a 12-bit sum
// with a sticky overflow flag, then holds the result until the consumer takes it.
module sum_accumulator #(
    parameter int N_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_sum,
    input  logic        in_cout,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] acc_out,
    output logic        acc_ovf,
    output logic [3:0]  count
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_SAMPLES - 1);

    state_t      state;
    logic [11:0] operand;
    logic [12:0] sum_ext;

    assign operand = {3'b000, in_cout, in_sum};
    // Extra bit exposes the 12-bit carry that feeds the sticky overflow.
    assign sum_ext = {1'b0, acc_out} + {1'b0, operand};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        acc_out  <= '0;
                        acc_ovf  <= 1'b0;
                        count    <= '0;
                        in_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_out <= sum_ext[11:0];
                        count   <= count + 4'd1;
                        if (sum_ext[12])
                            acc_ovf <= 1'b1;
                        // Final word: stop accepting and present the result next cycle.
                        if (count == LAST_IDX) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default N=8 instance plus an N=9 instance
// for the overflow case; expected values are hand-computed constants.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start9;
    logic        in_valid;
    logic [7:0]  in_sum;
    logic        in_cout;
    logic        out_ready, out_ready9;

    logic        in_ready, out_valid, acc_ovf;
    logic [11:0] acc_out;
    logic [3:0]  count;
    logic        in_ready9, out_valid9, acc_ovf9;
    logic [11:0] acc_out9;
    logic [3:0]  count9;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .acc_ovf(acc_ovf), .count(count)
    );

    sum_accumulator #(.N_SAMPLES(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .in_valid(in_valid),
        .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready9),
        .out_valid(out_valid9), .out_ready(out_ready9), .acc_out(acc_out9),
        .acc_ovf(acc_ovf9), .count(count9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start9 = 1'b0; in_valid = 1'b0;
        in_sum = 8'h00; in_cout = 1'b0; out_ready = 1'b0; out_ready9 = 1'b0;
        #1;
        chk("rst_acc", acc_out, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", acc_ovf, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Run 1: 8 x 398 = 3184 = 0xC70
        start = 1'b1; tick(); start = 1'b0;
        chk("r1_in_ready", in_ready, 1);
        chk("r1_count0", count, 0);
        in_valid = 1'b1; in_cout = 1'b1; in_sum = 8'h8E;
        repeat (7) tick();
        chk("r1_count7", count, 7);
        chk("r1_not_done", out_valid, 0);
        tick();
        chk("r1_out_valid", out_valid, 1);
        chk("r1_acc", acc_out, 12'hC70);
        chk("r1_ovf", acc_ovf, 0);
        chk("r1_count8", count, 8);
        chk("r1_in_ready_done", in_ready, 0);

        // DONE holds for 5 cycles with in_valid=1 and no out_ready
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_acc", acc_out, 12'hC70);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b0; tick(); out_ready = 1'b0;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_acc_kept", acc_out, 12'hC70);
        chk("hs_count_kept", count, 8);

        // Run 2 straight after handshake: 8 x 511 with bubbles = 0xFF8
        start = 1'b1; tick(); start = 1'b0;
        chk("r2_cleared", acc_out, 0);
        in_cout = 1'b1; in_sum = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; tick();
            in_valid = 1'b0; tick();
            if (i == 2) chk("r2_count_bubbles", count, 3);
        end
        chk("r2_out_valid", out_valid, 1);
        chk("r2_acc", acc_out, 12'hFF8);
        chk("r2_ovf", acc_ovf, 0);
        chk("r2_count", count, 8);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Run 3: start ignored mid-run; 8 x 5 = 40
        start = 1'b1; tick(); start = 1'b0;
        in_cout = 1'b0; in_sum = 8'd5; in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
        chk("r3_start_ign_cnt", count, 2);
        chk("r3_start_ign_acc", acc_out, 12'd10);
        in_valid = 1'b1;
        repeat (5) tick();
        chk("r3_not_done", out_valid, 0);
        tick(); in_valid = 1'b0;
        chk("r3_out_valid", out_valid, 1);
        chk("r3_acc", acc_out, 12'h028);
        // out_ready ignored outside DONE is implicit; finish handshake
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // N=9 instance: 9 x 511 = 4599 -> 0x1F7 with overflow
        start9 = 1'b1; tick(); start9 = 1'b0;
        in_cout = 1'b1; in_sum = 8'hFF; in_valid = 1'b1;
        repeat (8) tick();
        chk("n9_ovf_before", acc_ovf9, 0);
        chk("n9_not_done", out_valid9, 0);
        tick(); in_valid = 1'b0;
        chk("n9_out_valid", out_valid9, 1);
        chk("n9_acc", acc_out9, 12'h1F7);
        chk("n9_ovf", acc_ovf9, 1);
        chk("n9_count", count9, 9);
        chk("n9_other_idle", out_valid, 0);
        out_ready9 = 1'b1; tick(); out_ready9 = 1'b0;
        chk("n9_ovf_sticky_idle", acc_ovf9, 1);
        start9 = 1'b1; tick(); start9 = 1'b0;
        chk("n9_ovf_cleared", acc_ovf9, 0);

        // Mid-run asynchronous reset
        start = 1'b1; tick(); start = 1'b0;
        in_cout = 1'b0; in_sum = 8'd100; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("pre_rst_acc", acc_out, 12'h12C);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_acc", acc_out, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", in_ready, 0);
        start = 1'b1; tick(); start = 1'b0;
        in_sum = 8'd1; in_valid = 1'b1;
        repeat (8) tick();
        in_valid = 1'b0;
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_acc", acc_out, 12'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
